// File: rtl/br_puf_pkg.sv
// Shared types and defaults for the butterfly-ring PUF controller.
package br_puf_pkg;
  localparam int CH_W              = 128;
  localparam int DEF_RESET_CYCLES  = 16;
  localparam int DEF_SETTLE_CYCLES = 64;
  localparam int DEF_NUM_EVAL      = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RING_RST,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;
endpackage

// File: rtl/br_sync2.sv
// Two-flop synchronizer for the free-running ring output.
module br_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ff_q <= '0;
    else       ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];
endmodule

// File: rtl/br_puf_ctrl.sv
// Butterfly-ring PUF controller: repeated reset/settle/sample of the ring,
// majority vote over NUM_EVAL samples, valid/ready response handshake.
module br_puf_ctrl
  import br_puf_pkg::*;
#(
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int NUM_EVAL      = DEF_NUM_EVAL
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            CH_VALID,
  output logic            CH_READY,
  input  logic [CH_W-1:0] CH_DATA,
  output logic            PUF_RESET,
  output logic [CH_W-1:0] PUF_C,
  input  logic            PUF_OUT,
  output logic            RESP_VALID,
  input  logic            RESP_READY,
  output logic            RESP_BIT,
  output logic [7:0]      RESP_ONES,
  output logic            RESP_UNSTABLE
);
  if (NUM_EVAL % 2 == 0 || NUM_EVAL < 1 || NUM_EVAL > 255 ||
      SETTLE_CYCLES < 3 || RESET_CYCLES < 1) begin : g_bad_params
    $error("br_puf_ctrl: illegal parameter set");
  end

  localparam int MAXC = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(MAXC);
  localparam int OW   = $clog2(NUM_EVAL + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   eval_q, eval_d;
  logic [OW-1:0]   ones_q, ones_d;
  logic [CH_W-1:0] c_q;
  logic            accept;
  logic            out_sync;

  br_sync2 u_sync (
    .clk_i (CLK),
    .rst_i (RESET),
    .d_i   (PUF_OUT),
    .q_o   (out_sync)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    eval_d    = eval_q;
    ones_d    = ones_q;
    CH_READY  = 1'b0;
    PUF_RESET = 1'b1;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        CH_READY = 1'b1;
        if (CH_VALID) begin
          accept  = 1'b1;
          state_d = ST_RING_RST;
          cnt_d   = '0;
          eval_d  = '0;
          ones_d  = '0;
        end
      end
      ST_RING_RST: begin
        if (cnt_q == CW'(RESET_CYCLES - 1)) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SETTLE: begin
        PUF_RESET = 1'b0;
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SAMPLE: begin
        PUF_RESET = 1'b0;
        ones_d    = ones_q + OW'(out_sync);
        eval_d    = eval_q + OW'(1);
        state_d   = (eval_d == OW'(NUM_EVAL)) ? ST_DONE : ST_RING_RST;
      end
      ST_DONE: begin
        if (RESP_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      eval_q  <= '0;
      ones_q  <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eval_q  <= eval_d;
      ones_q  <= ones_d;
      if (accept) c_q <= CH_DATA;
    end
  end

  // Response fields are gated by DONE so they read zero outside a response.
  assign PUF_C         = c_q;
  assign RESP_VALID    = (state_q == ST_DONE);
  assign RESP_BIT      = RESP_VALID && (ones_q > OW'(NUM_EVAL / 2));
  assign RESP_ONES     = RESP_VALID ? 8'(ones_q) : 8'd0;
  assign RESP_UNSTABLE = RESP_VALID && (ones_q != '0) && (ones_q != OW'(NUM_EVAL));
endmodule

// File: tb/tb_br_puf_ctrl.sv
// Directed bench for br_puf_ctrl with a behavioural ring model (parity of C or a fixed per-evaluation pattern).
module tb_br_puf_ctrl;
  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         CH_VALID = 1'b0;
  logic         CH_READY;
  logic [127:0] CH_DATA = '0;
  logic         PUF_RESET;
  logic [127:0] PUF_C;
  logic         PUF_OUT;
  logic         RESP_VALID;
  logic         RESP_READY = 1'b0;
  logic         RESP_BIT;
  logic [7:0]   RESP_ONES;
  logic         RESP_UNSTABLE;

  int nvec = 0;
  int nerr = 0;

  // Ring model: output is 0 while held in reset, else parity(C) or pat[evaluation index].
  logic       pmode = 1'b0;
  logic [3:0] pat = 4'b0000;
  int         ev_cnt = 0;
  int         ev_base = 0;
  logic [1:0] ev_sel;

  always @(negedge PUF_RESET) ev_cnt = ev_cnt + 1;
  assign ev_sel  = 2'(ev_cnt - ev_base);
  assign PUF_OUT = !PUF_RESET && (pmode ? pat[ev_sel] : ^PUF_C);

  always #5 CLK = ~CLK;

  br_puf_ctrl #(.RESET_CYCLES(2), .SETTLE_CYCLES(4), .NUM_EVAL(3)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .CH_VALID      (CH_VALID),
    .CH_READY      (CH_READY),
    .CH_DATA       (CH_DATA),
    .PUF_RESET     (PUF_RESET),
    .PUF_C         (PUF_C),
    .PUF_OUT       (PUF_OUT),
    .RESP_VALID    (RESP_VALID),
    .RESP_READY    (RESP_READY),
    .RESP_BIT      (RESP_BIT),
    .RESP_ONES     (RESP_ONES),
    .RESP_UNSTABLE (RESP_UNSTABLE)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic bit_e, input logic [7:0] ones_e,
                          input logic unst_e);
    chk({tag, " valid"},    RESP_VALID, 1'b1);
    chk({tag, " bit"},      RESP_BIT, bit_e);
    chk({tag, " ones"},     RESP_ONES, ones_e);
    chk({tag, " unstable"}, RESP_UNSTABLE, unst_e);
    chk({tag, " puf_rst"},  PUF_RESET, 1'b1);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, " ch_ready"}, CH_READY, 1'b1);
    chk({tag, " puf_rst"},  PUF_RESET, 1'b1);
    chk({tag, " puf_c"},    PUF_C, 128'h0);
    chk({tag, " valid"},    RESP_VALID, 1'b0);
    chk({tag, " bit"},      RESP_BIT, 1'b0);
    chk({tag, " ones"},     RESP_ONES, 8'h0);
    chk({tag, " unstable"}, RESP_UNSTABLE, 1'b0);
  endtask

  // Offer a challenge on the next edge (CH_READY is 1 there); leaves CH_VALID low afterwards.
  task automatic accept(input logic [127:0] d);
    ev_base  = ev_cnt;
    CH_VALID = 1'b1;
    CH_DATA  = d;
    tick;
    CH_VALID = 1'b0;
  endtask

  // Runs from just after the accepting edge; RESP_VALID must first be sampled
  // high at edge 3*(2+4+1)+1 = 22, i.e. it is first seen after edge 21.
  task automatic wait_done(input string tag, input logic [127:0] expc);
    int first;
    logic busy_ok;
    first   = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      if (CH_READY !== 1'b0 || PUF_C !== expc) busy_ok = 1'b0;
      tick;
      if (RESP_VALID === 1'b1) begin
        first = i;
        break;
      end
    end
    chk({tag, " busy ready=0/C held"}, busy_ok, 1'b1);
    chk({tag, " latency"}, first, 21);
  endtask

  initial begin
    // Reset state while RESET is held
    #3;
    chk_idle_outs("rst");
    tick; tick;
    RESET = 1'b0;
    tick;
    chk_idle_outs("post_rst");

    // C=1: parity 1 every evaluation -> 3 ones, bit 1, stable
    accept(128'h1);
    chk("t1 puf_c", PUF_C, 128'h1);
    chk("t1 puf_rst in RING_RST", PUF_RESET, 1'b1);
    wait_done("t1", 128'h1);
    chk_resp("t1", 1'b1, 8'd3, 1'b0);

    // Consumer stalls 10 cycles: response and PUF_RESET must hold
    begin
      logic hold_ok;
      hold_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick;
        if (RESP_VALID !== 1'b1 || RESP_BIT !== 1'b1 || RESP_ONES !== 8'd3 ||
            RESP_UNSTABLE !== 1'b0 || PUF_RESET !== 1'b1 || CH_READY !== 1'b0) hold_ok = 1'b0;
      end
      chk("t1 stall hold", hold_ok, 1'b1);
    end
    RESP_READY = 1'b1;
    tick;
    RESP_READY = 1'b0;
    chk("t1 handshake valid", RESP_VALID, 1'b0);
    chk("t1 handshake ready", CH_READY, 1'b1);
    chk("t1 C kept", PUF_C, 128'h1);

    // Pattern 1,0,1 with CH_VALID held high and different data while busy
    pmode = 1'b1;
    pat   = 4'b1010;
    accept(128'hA5);
    CH_VALID = 1'b1;
    CH_DATA  = 128'hDEAD_BEEF;
    wait_done("t2", 128'hA5);
    CH_VALID = 1'b0;
    chk_resp("t2", 1'b1, 8'd2, 1'b1);
    chk("t2 C held", PUF_C, 128'hA5);
    RESP_READY = 1'b1;
    tick;
    RESP_READY = 1'b0;
    chk("t2 handshake valid", RESP_VALID, 1'b0);

    // C=3: parity 0 every evaluation -> 0 ones, bit 0, stable
    pmode = 1'b0;
    accept(128'h3);
    wait_done("t3", 128'h3);
    chk_resp("t3", 1'b0, 8'd0, 1'b0);
    RESP_READY = 1'b1;
    tick;
    RESP_READY = 1'b0;

    // Reset during SETTLE of the second evaluation (edges 9..12 after accept)
    accept(128'h7);
    for (int i = 0; i < 10; i++) tick;
    chk("t4 in settle", PUF_RESET, 1'b0);
    RESET = 1'b1;
    #1;
    chk_idle_outs("t4 async rst");
    tick;
    RESET = 1'b0;
    begin
      logic quiet_ok;
      quiet_ok = 1'b1;
      for (int i = 0; i < 30; i++) begin
        tick;
        if (RESP_VALID !== 1'b0 || CH_READY !== 1'b1) quiet_ok = 1'b0;
      end
      chk("t4 no response after abort", quiet_ok, 1'b1);
    end
    accept(128'h7);
    wait_done("t4b", 128'h7);
    chk_resp("t4b", 1'b1, 8'd3, 1'b0);
    RESP_READY = 1'b1;
    tick;
    RESP_READY = 1'b0;
    chk("t4b back idle", CH_READY, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
